// File: rtl/pair_former.sv
// pair_former: packs a 16-bit element stream into {a,b} pairs in a FIFO_DEPTH-entry FIFO, one cycle push-to-valid_out, ready_in low only when full.
// Define PAIR_FORMER_PAD_EN to pad an odd final element with PAD_VALUE; otherwise it is dropped and odd_drop pulses.
module pair_former #(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] PAD_VALUE  = 16'h0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] data_in,
   input  logic        valid_in,
   input  logic        last_in,
   output logic        ready_in,
   output logic [15:0] data_out_a,
   output logic [15:0] data_out_b,
   output logic        valid_out,
   input  logic        ready_out,
   output logic [7:0]  pair_count,
   output logic        odd_drop
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
   } pair_t;

   typedef enum logic {
      WAIT_A = 1'b0,
      HAVE_A = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [15:0]   r_hold;
   pair_t         r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [7:0]    r_pair_count;
   logic          r_odd_drop;

   logic          w_accept;
   logic          w_pop;
   logic          w_push;
   logic          w_hold_ld;
   logic          w_drop;
   pair_t         w_pair;
   pair_t         w_head;

   // Flow control depends on occupancy only, never on this cycle's handshake inputs.
   assign ready_in   = (r_count < CW'(FIFO_DEPTH));
   assign valid_out  = (r_count != '0);
   assign w_accept   = valid_in & ready_in;
   assign w_pop      = valid_out & ready_out;

   assign w_head     = r_mem[r_rd_ptr];
   assign data_out_a = w_head.a;
   assign data_out_b = w_head.b;
   assign pair_count = r_pair_count;
   assign odd_drop   = r_odd_drop;

   // In WAIT_A the only pair that can be pushed is a padded odd tail.
   assign w_pair = (r_state == HAVE_A) ? {r_hold, data_in} : {data_in, PAD_VALUE};

   always_comb begin
      w_state_nxt = r_state;
      w_push      = 1'b0;
      w_hold_ld   = 1'b0;
      w_drop      = 1'b0;
      case (r_state)
         WAIT_A: begin
            if (w_accept) begin
               if (!last_in) begin
                  w_hold_ld   = 1'b1;
                  w_state_nxt = HAVE_A;
               end else begin
`ifdef PAIR_FORMER_PAD_EN
                  w_push = 1'b1;
`else
                  w_drop = 1'b1;
`endif
               end
            end
         end
         HAVE_A: begin
            if (w_accept) begin
               w_push      = 1'b1;
               w_state_nxt = WAIT_A;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= WAIT_A;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_pair_count <= '0;
         r_odd_drop   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_odd_drop <= w_drop;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_pop && (r_pair_count != 8'hFF)) begin
            r_pair_count <= r_pair_count + 8'd1;
         end
      end
   end

   // Data path needs no reset: occupancy and FSM state gate every use.
   always_ff @(posedge clk) begin
      if (w_hold_ld) begin
         r_hold <= data_in;
      end
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_pair;
      end
   end

endmodule

// File: tb/tb_pair_former.sv
// Directed bench for pair_former: queue-based reference model checked every cycle, plus literal pair lists per scenario.
module tb_pair_former;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] data_in = '0;
   logic        valid_in = 1'b0;
   logic        last_in = 1'b0;
   logic        ready_in;
   logic [15:0] data_out_a;
   logic [15:0] data_out_b;
   logic        valid_out;
   logic        ready_out = 1'b0;
   logic [7:0]  pair_count;
   logic        odd_drop;

   int total = 0;
   int bad   = 0;

   pair_former #(.FIFO_DEPTH(DEPTH), .PAD_VALUE(16'h0000)) dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .last_in   (last_in),
      .ready_in  (ready_in),
      .data_out_a(data_out_a),
      .data_out_b(data_out_b),
      .valid_out (valid_out),
      .ready_out (ready_out),
      .pair_count(pair_count),
      .odd_drop  (odd_drop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a queue of {a,b} pairs, a pending odd element, a saturating pop counter.
   logic [31:0] mq[$];
   bit          m_have = 0;
   logic [15:0] m_hold = '0;
   int          m_pc = 0;
   bit          m_drop = 0;

   always @(posedge clk or posedge rst) begin
      bit acc;
      bit pop;
      if (rst) begin
         mq.delete();
         m_have = 0;
         m_pc   = 0;
         m_drop = 0;
      end else begin
         acc    = valid_in && (mq.size() < DEPTH);
         pop    = (mq.size() != 0) && ready_out;
         m_drop = 0;
         if (pop) begin
            void'(mq.pop_front());
            if (m_pc < 255) m_pc++;
         end
         if (acc) begin
            if (m_have) begin
               mq.push_back({m_hold, data_in});
               m_have = 0;
            end else if (!last_in) begin
               m_hold = data_in;
               m_have = 1;
            end else begin
`ifdef PAIR_FORMER_PAD_EN
               mq.push_back({data_in, 16'h0000});
`else
               m_drop = 1;
`endif
            end
         end
      end
   end

   // Every-cycle comparison, away from the active edge.
   bit          cap_vld = 0;
   logic [31:0] cap_dat = '0;
   logic [31:0] got[$];
   logic [31:0] exp_q[$];

   always @(negedge clk) begin
      chk("valid_out", 32'(valid_out), 32'(mq.size() != 0));
      chk("ready_in", 32'(ready_in), 32'(mq.size() < DEPTH));
      chk("pair_count", 32'(pair_count), 32'(m_pc));
      chk("odd_drop", 32'(odd_drop), 32'(m_drop));
      if (mq.size() != 0) chk("head_pair", {data_out_a, data_out_b}, mq[0]);
      cap_vld = valid_out;
      cap_dat = {data_out_a, data_out_b};
   end

   always @(posedge clk) begin
      if (!rst && cap_vld && ready_out) got.push_back(cap_dat);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic send(input logic [15:0] d, input logic l);
      int n;
      n = 0;
      data_in  = d;
      last_in  = l;
      valid_in = 1'b1;
      while (ready_in !== 1'b1) begin
         tick();
         n++;
         if (n > 100) begin
            total++;
            bad++;
            $display("FAIL send_timeout: ready_in stuck at %b for data %h", ready_in, d);
            valid_in = 1'b0;
            return;
         end
      end
      tick();
      valid_in = 1'b0;
      last_in  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      ready_out = 1'b1;
      while (valid_out === 1'b1 && n <= 100) begin
         tick();
         n++;
      end
      if (n > 100) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: valid_out still %b", valid_out);
      end
   endtask

   task automatic do_reset();
      ready_out = 1'b0;
      valid_in  = 1'b0;
      rst       = 1'b1;
      tick();
      rst       = 1'b0;
      got.delete();
   endtask

   task automatic check_got(input string nm);
      chk({nm, "_len"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(nm, got[i], exp_q[i]);
   endtask

   initial begin
      #1;
      rst = 1'b1;
      tick();
      chk("rst_valid_out", 32'(valid_out), 32'd0);
      chk("rst_ready_in", 32'(ready_in), 32'd1);
      chk("rst_pair_count", 32'(pair_count), 32'd0);
      tick();
      rst = 1'b0;

      // Basic pair, visible one cycle after the second beat.
      ready_out = 1'b1;
      send(16'h1111, 1'b0);
      send(16'h2222, 1'b1);
      chk("basic_valid", 32'(valid_out), 32'd1);
      chk("basic_pair", {data_out_a, data_out_b}, 32'h1111_2222);
      tick();
      chk("basic_count", 32'(pair_count), 32'd1);
      exp_q = {32'h1111_2222};
      check_got("basic_got");

      // Fill to full with downstream stalled, then drain in order.
      do_reset();
      for (int i = 1; i <= 8; i++) send(16'(i), i == 8);
      chk("full_ready_in", 32'(ready_in), 32'd0);
      chk("full_head", {data_out_a, data_out_b}, 32'h0001_0002);
      tick();
      chk("stall_head", {data_out_a, data_out_b}, 32'h0001_0002);
      drain();
      chk("fill_count", 32'(pair_count), 32'd4);
      exp_q = {32'h0001_0002, 32'h0003_0004, 32'h0005_0006, 32'h0007_0008};
      check_got("fill_got");

      // Full FIFO with both sides active; order holds across pointer wrap.
      do_reset();
      for (int i = 0; i < 8; i++) send(16'h0011 + 16'(i), 1'b0);
      ready_out = 1'b1;
      chk("wrap_ready_in_full", 32'(ready_in), 32'd0);
      for (int i = 0; i < 8; i++) send(16'h0021 + 16'(i), i == 7);
      drain();
      exp_q = {32'h0011_0012, 32'h0013_0014, 32'h0015_0016, 32'h0017_0018,
               32'h0021_0022, 32'h0023_0024, 32'h0025_0026, 32'h0027_0028};
      check_got("wrap_got");
      chk("wrap_count", 32'(pair_count), 32'd8);

      // Odd-length stream.
      do_reset();
      ready_out = 1'b1;
      send(16'hAAAA, 1'b0);
      send(16'hBBBB, 1'b0);
      send(16'hCCCC, 1'b1);
`ifdef PAIR_FORMER_PAD_EN
      chk("odd_drop_pulse", 32'(odd_drop), 32'd0);
`else
      chk("odd_drop_pulse", 32'(odd_drop), 32'd1);
`endif
      tick();
      chk("odd_drop_after", 32'(odd_drop), 32'd0);
      drain();
`ifdef PAIR_FORMER_PAD_EN
      exp_q = {32'hAAAA_BBBB, 32'hCCCC_0000};
`else
      exp_q = {32'hAAAA_BBBB};
`endif
      check_got("odd_got");

      // Reset mid-stream discards the held element and buffered pairs.
      do_reset();
      send(16'h0001, 1'b0);
      send(16'h0002, 1'b0);
      send(16'h0003, 1'b0);
      send(16'h0004, 1'b0);
      send(16'h5555, 1'b0);
      chk("mid_valid_before", 32'(valid_out), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_valid_out", 32'(valid_out), 32'd0);
      chk("mid_ready_in", 32'(ready_in), 32'd1);
      chk("mid_pair_count", 32'(pair_count), 32'd0);
      chk("mid_odd_drop", 32'(odd_drop), 32'd0);
      tick();
      rst = 1'b0;
      got.delete();
      ready_out = 1'b1;
      send(16'h6666, 1'b0);
      send(16'h7777, 1'b1);
      drain();
      exp_q = {32'h6666_7777};
      check_got("mid_got");

      // pair_count saturates at 255.
      do_reset();
      ready_out = 1'b1;
      for (int i = 0; i < 520; i++) send(16'(i), i == 519);
      drain();
      chk("sat_count", 32'(pair_count), 32'd255);
      chk("sat_got_len", 32'(got.size()), 32'd260);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/pair_former.md
PAIR_FORMER -- requirements
Module: pair_former

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: number of buffered pairs; power of two, 2..16.
REQ-002 Parameter PAD_VALUE, default 16'h0000: fill value for the b half of an incomplete final pair.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 data_in  input  16  scalar element stream.
REQ-006 valid_in  input  1  data_in/last_in valid.
REQ-007 last_in  input  1  marks final element of a stream; sampled only on accepted beats.
REQ-008 ready_in  output  1  block can accept an element this cycle.
REQ-009 data_out_a  output  16  first element of head pair.
REQ-010 data_out_b  output  16  second element of head pair.
REQ-011 valid_out  output  1  head pair valid.
REQ-012 ready_out  input  1  downstream (concat stage) accepts head pair.
REQ-013 pair_count  output  8  pairs popped since reset; saturates at 255.
REQ-014 odd_drop  output  1  one-cycle pulse when an unpaired final element is discarded.

Function
REQ-015 An input beat is accepted when valid_in && ready_in; an output pair is popped when valid_out && ready_out.
REQ-016 Two-state pairing FSM: WAIT_A (hold register empty) and HAVE_A (hold register holds element a).
REQ-017 WAIT_A, accepted beat with last_in=0: data_in -> hold register, go to HAVE_A.
REQ-018 HAVE_A, accepted beat (any last_in): push {hold, data_in} as {a, b} into FIFO, go to WAIT_A.
REQ-019 WAIT_A, accepted beat with last_in=1: handled per Configuration; FSM stays in WAIT_A.
REQ-020 ready_in = (count < FIFO_DEPTH) in both states, driven only from registers (no combinational path from valid_in, last_in or ready_out).
REQ-021 valid_out = (count != 0); data_out_a/data_out_b = FIFO head entry, read combinationally from the storage array.
REQ-022 Latency: a pair pushed at edge N is visible on valid_out in the cycle after edge N; no bypass.
REQ-023 Simultaneous push and pop: count unchanged, both pointers advance; accepting a push when count==FIFO_DEPTH is impossible because ready_in=0.
REQ-024 Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits wide.
REQ-025 Head pair, and data_out_a/b, stay stable while valid_out=1 and ready_out=0.
REQ-026 pair_count increments by 1 per pop and holds at 8'hFF.
REQ-027 odd_drop is a registered pulse, asserted exactly one cycle, the cycle after the discarding beat.

Reset
REQ-028 rst asserted: FSM to WAIT_A, count/pointers to 0, pair_count 0, odd_drop 0, valid_out 0, ready_in 1; hold register and storage contents need not be cleared.
REQ-029 rst asserted mid-stream discards any held element and all buffered pairs without an odd_drop pulse.

Configuration
REQ-030 Macro PAIR_FORMER_PAD_EN defined: REQ-019 pushes {data_in, PAD_VALUE} as {a, b}; odd_drop tied 0.
REQ-031 PAIR_FORMER_PAD_EN undefined: REQ-019 discards data_in, pushes nothing, pulses odd_drop.

Verification
REQ-032 After reset, send 16'h1111, 16'h2222 (last_in on 2nd), ready_out=1 -> one pair a=1111, b=2222 exactly one cycle after the 2nd beat, pair_count=1.
REQ-033 ready_out=0, stream 8 elements 16'h0001..16'h0008 -> ready_in drops after 4 pairs; then ready_out=1 -> pairs (1,2),(3,4),(5,6),(7,8) in order, pair_count=4.
REQ-034 Full FIFO, valid_in=1 and ready_out=1 for 4 cycles -> ready_in stays 0 until first pop updates count, no element lost or duplicated, order preserved across pointer wrap.
REQ-035 Send 16'hAAAA, 16'hBBBB, 16'hCCCC (last_in on 3rd): with PAIR_FORMER_PAD_EN -> pairs (AAAA,BBBB),(CCCC,0000); without -> pair (AAAA,BBBB) only and one odd_drop pulse.
REQ-036 Accept 16'h5555 (FSM in HAVE_A) plus 2 buffered pairs, assert rst for 1 cycle -> valid_out=0, ready_in=1, pair_count=0, odd_drop=0; next pair formed from fresh elements only.
